// File: rtl/axi_std_master.sv
// axi_std_master
//   AXI4 initiator that turns one command (address, LEN, read/write) into a
//   single INCR burst. Write beats arrive on wr_* (valid/ready stream), read
//   beats leave on rd_* (valid/ready stream). One transaction at a time.
// Ports
//   m00_axi_aclk / m00_axi_areset : clock, async active-high reset
//   cmd_*                         : command handshake (rnw, addr, len)
//   wr_*                          : write-data stream into the W channel
//   rd_*                          : read-data stream out of the R channel
//   done / done_resp              : end-of-transaction pulse + worst response
//   m00_axi_aw*/w*/b*/ar*/r*      : AXI4 master channels
module axi_std_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 10
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                      cmd_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic                            rd_last,
  output logic                            done,
  output logic [1:0]                      done_resp,
  output logic [C_M_AXI_ID_WIDTH-1:0]     m00_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]                      m00_axi_awlen,
  output logic [2:0]                      m00_axi_awsize,
  output logic [1:0]                      m00_axi_awburst,
  output logic                            m00_axi_awlock,
  output logic [3:0]                      m00_axi_awcache,
  output logic [2:0]                      m00_axi_awprot,
  output logic [3:0]                      m00_axi_awqos,
  output logic [3:0]                      m00_axi_awregion,
  output logic                            m00_axi_awuser,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                            m00_axi_wlast,
  output logic                            m00_axi_wuser,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     m00_axi_bid,
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  output logic [C_M_AXI_ID_WIDTH-1:0]     m00_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [7:0]                      m00_axi_arlen,
  output logic [2:0]                      m00_axi_arsize,
  output logic [1:0]                      m00_axi_arburst,
  output logic                            m00_axi_arlock,
  output logic [3:0]                      m00_axi_arcache,
  output logic [2:0]                      m00_axi_arprot,
  output logic [3:0]                      m00_axi_arqos,
  output logic [3:0]                      m00_axi_arregion,
  output logic                            m00_axi_aruser,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     m00_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rlast,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready
);
  localparam int SIZE = $clog2(C_M_AXI_DATA_WIDTH/8);
  localparam int AW   = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, AW_S, W_S, B_S, AR_S, R_S} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [1:0]     sticky_q, sticky_d;
  logic           done_q, done_d;
  logic [1:0]     resp_q, resp_d;
  logic           last;
  logic [1:0]     fold;

  // 8-bit counter against 8-bit LEN: the terminal compare fires at 255
  // before the counter could ever wrap.
  assign last = (cnt_q == len_q);

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      done_q   <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    resp_d   = resp_q;
    fold     = sticky_q;
    cmd_ready       = 1'b0;
    m00_axi_awvalid = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_wvalid  = 1'b0;
    wr_ready        = 1'b0;
    m00_axi_bready  = 1'b0;
    m00_axi_rready  = 1'b0;
    rd_valid        = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so every ready reads 0 while reset is held.
        cmd_ready = ~m00_axi_areset;
        if (cmd_valid) begin
          addr_d   = {cmd_addr[AW-1:SIZE], {SIZE{1'b0}}};
          len_d    = cmd_len;
          cnt_d    = '0;
          sticky_d = '0;
          state_d  = cmd_rnw ? AR_S : AW_S;
        end
      end
      AW_S: begin
        m00_axi_awvalid = 1'b1;
        if (m00_axi_awready) state_d = W_S;
      end
      W_S: begin
        m00_axi_wvalid = wr_valid;
        wr_ready       = m00_axi_wready;
        if (wr_valid && m00_axi_wready) begin
          if (last) begin
            cnt_d   = '0;
            state_d = B_S;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      B_S: begin
        m00_axi_bready = 1'b1;
        if (m00_axi_bvalid) begin
          done_d  = 1'b1;
          resp_d  = m00_axi_bresp;
          state_d = IDLE;
        end
      end
      AR_S: begin
        m00_axi_arvalid = 1'b1;
        if (m00_axi_arready) state_d = R_S;
      end
      R_S: begin
        m00_axi_rready = rd_ready;
        rd_valid       = m00_axi_rvalid;
        if (m00_axi_rvalid && rd_ready) begin
          // Worst-case fold; an rlast that disagrees with our own count is
          // a protocol error and is reported as at least SLVERR.
          if (m00_axi_rresp > fold) fold = m00_axi_rresp;
          if ((m00_axi_rlast != last) && (fold < 2'b10)) fold = 2'b10;
          sticky_d = fold;
          if (last) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            resp_d  = fold;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = done_q;
  assign done_resp = resp_q;

  assign m00_axi_awid     = '0;
  assign m00_axi_awaddr   = addr_q;
  assign m00_axi_awlen    = len_q;
  assign m00_axi_awsize   = 3'(SIZE);
  assign m00_axi_awburst  = 2'b01;
  assign m00_axi_awlock   = 1'b0;
  assign m00_axi_awcache  = 4'b0011;
  assign m00_axi_awprot   = 3'b000;
  assign m00_axi_awqos    = 4'b0000;
  assign m00_axi_awregion = 4'b0000;
  assign m00_axi_awuser   = 1'b0;

  assign m00_axi_wdata = wr_data;
  assign m00_axi_wstrb = '1;
  assign m00_axi_wlast = (state_q == W_S) && last;
  assign m00_axi_wuser = 1'b0;

  assign m00_axi_arid     = '0;
  assign m00_axi_araddr   = addr_q;
  assign m00_axi_arlen    = len_q;
  assign m00_axi_arsize   = 3'(SIZE);
  assign m00_axi_arburst  = 2'b01;
  assign m00_axi_arlock   = 1'b0;
  assign m00_axi_arcache  = 4'b0011;
  assign m00_axi_arprot   = 3'b000;
  assign m00_axi_arqos    = 4'b0000;
  assign m00_axi_arregion = 4'b0000;
  assign m00_axi_aruser   = 1'b0;

  assign rd_data = m00_axi_rdata;
  assign rd_last = (state_q == R_S) && last;

  // Response IDs are deliberately not checked; low address bits are dropped.
  logic unused_ok;
  assign unused_ok = ^{m00_axi_bid, m00_axi_rid, cmd_addr[SIZE-1:0]};
endmodule

// File: tb/tb_axi_std_master.sv
module tb_axi_std_master;
  localparam int DW = 512;
  localparam int AW = 10;
  localparam int IW = 1;
  localparam int BOUND = 5000;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic wr_valid, wr_ready, rd_valid, rd_ready, rd_last, done;
  logic [1:0] done_resp;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awuser, aruser, wuser;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int errs = 0;
  int checks = 0;
  logic [DW-1:0] dq [256];
  logic [1:0] rsp [256];
  logic lst [256];

  always #5 clk = ~clk;

  axi_std_master dut (
    .m00_axi_aclk(clk), .m00_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awlock(awlock),
    .m00_axi_awcache(awcache), .m00_axi_awprot(awprot), .m00_axi_awqos(awqos),
    .m00_axi_awregion(awregion), .m00_axi_awuser(awuser),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wuser(wuser), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid),
    .m00_axi_bready(bready),
    .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arlock(arlock),
    .m00_axi_arcache(arcache), .m00_axi_arprot(arprot), .m00_axi_arqos(arqos),
    .m00_axi_arregion(arregion), .m00_axi_aruser(aruser),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rid(rid), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_rnw = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    awready = 0; wready = 0; arready = 0;
    bid = '0; bresp = '0; bvalid = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_handshakes"},
        {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done}, '0);
  endtask

  task automatic send_cmd(input logic rnw, input logic [AW-1:0] addr, input logic [7:0] len);
    cmd_valid = 1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic write_txn(input logic [AW-1:0] addr, input logic [7:0] len,
                           input bit stall, input int abort_at);
    logic [AW-1:0] ea;
    logic [1:0] br;
    int i, cyc, n;
    ea = {addr[AW-1:6], 6'b0};
    for (int k = 0; k <= int'(len); k++) dq[k] = rnd();
    send_cmd(1'b0, addr, len);
    n = stall ? int'($urandom_range(1, 3)) : 0;
    // AW phase: early write data and an early B response must not leak through.
    for (int k = 0; k <= n; k++) begin
      awready = (k == n); bvalid = (k != n);
      wr_valid = 1; wr_data = dq[0]; wready = 1;
      #1;
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, ea);
      chk("awlen", awlen, len);
      chk("awsize_burst", {awsize, awburst}, {3'd6, 2'b01});
      chk("aw_no_early_w", wvalid, 0);
      chk("aw_no_early_b", bready, 0);
      tick();
    end
    awready = 0; bvalid = 0;
    i = 0; cyc = 0;
    while (i <= int'(len) && cyc < BOUND) begin
      if (abort_at >= 0 && i == abort_at) begin
        wr_valid = 1; wready = 1; wr_data = dq[i];
        #1;
        chk("abort_pre_wvalid", wvalid, 1);
        rst = 1;
        #1;
        chk_all_quiet("abort_async");
        tick();
        chk_all_quiet("abort_held");
        rst = 0;
        idle_inputs();
        tick();
        return;
      end
      wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = wr_valid ? dq[i] : rnd();
      #1;
      chk("wvalid", wvalid, wr_valid);
      chk("wr_ready", wr_ready, wready);
      chk("w_awvalid_low", awvalid, 0);
      if (wr_valid) begin
        chk("wdata", wdata, dq[i]);
        chk("wlast", wlast, (i == int'(len)));
        chk("wstrb", wstrb, {(DW/8){1'b1}});
      end
      if (wr_valid && wready) i++;
      tick();
      cyc++;
    end
    chk("w_timeout", (cyc < BOUND), 1);
    wr_valid = 0; wready = 0;
    n = stall ? int'($urandom_range(0, 2)) : 0;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("bready_wait", bready, 1);
      chk("done_early", done, 0);
      tick();
    end
    br = 2'($urandom_range(0, 3));
    bvalid = 1; bresp = br;
    #1;
    chk("bready", bready, 1);
    tick();
    bvalid = 0; bresp = 0;
    #1;
    chk("w_done", done, 1);
    chk("w_done_resp", done_resp, br);
    chk("w_cmd_ready_after", cmd_ready, 1);
    tick();
    chk("w_done_pulse", done, 0);
  endtask

  task automatic read_default(input logic [7:0] len);
    for (int k = 0; k <= int'(len); k++) begin
      rsp[k] = 2'b00;
      lst[k] = (k == int'(len));
    end
  endtask

  task automatic read_txn(input logic [AW-1:0] addr, input logic [7:0] len, input bit stall);
    logic [AW-1:0] ea;
    logic [1:0] exp;
    bit mism;
    int i, cyc, n;
    ea = {addr[AW-1:6], 6'b0};
    // Expected response: worst rresp over the burst; an rlast placed on any
    // beat other than the LEN-th one counts as at least SLVERR.
    exp = 2'b00; mism = 0;
    for (int k = 0; k <= int'(len); k++) begin
      dq[k] = rnd();
      if (rsp[k] > exp) exp = rsp[k];
      if (lst[k] != (k == int'(len))) mism = 1;
    end
    if (mism && exp < 2'b10) exp = 2'b10;
    send_cmd(1'b1, addr, len);
    n = stall ? int'($urandom_range(1, 3)) : 0;
    for (int k = 0; k <= n; k++) begin
      arready = (k == n); rvalid = (k != n); rd_ready = 1;
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, ea);
      chk("arlen", arlen, len);
      chk("arsize_burst", {arsize, arburst}, {3'd6, 2'b01});
      chk("ar_no_early_r", {rready, rd_valid}, 2'b00);
      tick();
    end
    arready = 0; rvalid = 0;
    i = 0; cyc = 0;
    while (i <= int'(len) && cyc < BOUND) begin
      rvalid   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata = dq[i]; rresp = rsp[i]; rlast = lst[i];
      #1;
      chk("rready", rready, rd_ready);
      chk("rd_valid", rd_valid, rvalid);
      if (rvalid) begin
        chk("rd_data", rd_data, dq[i]);
        chk("rd_last", rd_last, (i == int'(len)));
      end
      if (rvalid && rd_ready) i++;
      tick();
      cyc++;
    end
    chk("r_timeout", (cyc < BOUND), 1);
    rvalid = 0; rd_ready = 0; rlast = 0; rresp = 0;
    #1;
    chk("r_done", done, 1);
    chk("r_done_resp", done_resp, exp);
    chk("r_cmd_ready_after", cmd_ready, 1);
    tick();
    chk("r_done_pulse", done, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    chk_all_quiet("reset");
    chk("reset_done_resp", done_resp, 0);
    chk("tieoffs", {awcache, arcache, awlock, awqos, awregion, awprot, awuser, wuser},
        {4'b0011, 4'b0011, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0});
    tick();
    rst = 0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    tick();

    write_txn(10'h040, 8'd3, 1'b0, -1);
    read_default(8'd0);
    read_txn(10'h000, 8'd0, 1'b0);
    write_txn(10'h1C5, 8'd7, 1'b1, -1);

    read_default(8'd3);
    rsp[2] = 2'b10;
    read_txn(10'h080, 8'd3, 1'b0);

    read_default(8'd3);
    lst[1] = 1'b1;
    read_txn(10'h0C0, 8'd3, 1'b1);

    read_default(8'd3);
    for (int k = 0; k < 4; k++) rsp[k] = 2'($urandom_range(0, 1));
    read_txn(10'h100, 8'd3, 1'b1);

    read_default(8'd255);
    read_txn(10'h000, 8'd255, 1'b1);

    write_txn(10'h200, 8'd5, 1'b0, 2);
    write_txn(10'h240, 8'd2, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
